// File: rtl/pixel_commit_if.sv
// Framebuffer write bus between pixel_commit (master) and the framebuffer (slave).
// fb_we is the request/valid; fb_ready accepts it in the same cycle.
interface pixel_commit_if;
   logic [16:0] fb_addr;
   logic [5:0]  fb_data;
   logic        fb_we;
   logic        fb_ready;

   modport master (output fb_addr, output fb_data, output fb_we, input fb_ready);
   modport slave  (input fb_addr, input fb_data, input fb_we, output fb_ready);
endinterface

// File: rtl/pixel_commit.sv
// Buffers drawing-engine pixels in a small FIFO, clips off-screen pixels and
// commits them to the framebuffer; signals frame_done once a finished frame drains.
module pixel_commit #(
   parameter int unsigned WIDTH  = 320,
   parameter int unsigned HEIGHT = 240,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [8:0]           x_in,
   input  logic [7:0]           y_in,
   input  logic [5:0]           colour_in,
   input  logic                 write_en,
   input  logic                 finished_in,
   output logic                 busy,
   pixel_commit_if.master       fb,
   output logic                 frame_done,
   output logic                 overflow,
   output logic [15:0]          clip_count
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

   state_t        state;
   logic [22:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic          accept;
   logic          clip;
   logic          push;
   logic          pop;
   logic [16:0]   pix_addr;

   assign busy     = (count == CW'(DEPTH));
   assign accept   = write_en && !busy;
   assign clip     = (32'(x_in) >= WIDTH) || (32'(y_in) >= HEIGHT);
   assign push     = accept && !clip;
   assign pop      = fb.fb_we && fb.fb_ready;
   assign pix_addr = 17'(y_in) * 17'(WIDTH) + 17'(x_in);

   assign fb.fb_we = (count != '0);
   assign {fb.fb_addr, fb.fb_data} = mem[rd_ptr];

   always_comb begin
      count_next = count;
      unique case ({push, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // Storage carries no reset: entries are only observed while count != 0.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {pix_addr, colour_in};
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
         clip_count <= '0;
      end else begin
         count      <= count_next;
         frame_done <= 1'b0;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (write_en && busy) overflow <= 1'b1;
         if (accept && clip && clip_count != '1) clip_count <= clip_count + 16'd1;

         unique case (state)
            IDLE: begin
               if (finished_in)  state <= DRAIN;
               else if (accept)  state <= STREAM;
            end
            STREAM: begin
               if (finished_in) state <= DRAIN;
            end
            // Empty check uses count_next so a final pop this cycle completes the frame.
            DRAIN: begin
               if (count_next == '0) begin
                  state      <= DONE;
                  frame_done <= 1'b1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pixel_commit.sv
// Directed bench for pixel_commit: a vector table for the streaming/backpressure/
// clipping behaviour plus hand sequences for frame end, empty frame and reset.
module tb_pixel_commit;
   logic        clk;
   logic        reset_n;
   logic [8:0]  x_in;
   logic [7:0]  y_in;
   logic [5:0]  colour_in;
   logic        write_en;
   logic        finished_in;
   logic        busy;
   logic        frame_done;
   logic        overflow;
   logic [15:0] clip_count;

   int unsigned passed;
   int unsigned total;

   pixel_commit_if fb_bus ();

   pixel_commit #(.WIDTH(320), .HEIGHT(240), .DEPTH(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .x_in        (x_in),
      .y_in        (y_in),
      .colour_in   (colour_in),
      .write_en    (write_en),
      .finished_in (finished_in),
      .busy        (busy),
      .fb          (fb_bus.master),
      .frame_done  (frame_done),
      .overflow    (overflow),
      .clip_count  (clip_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [8:0]  x;
      logic [7:0]  y;
      logic [5:0]  c;
      logic        rdy;
      logic        e_we;
      logic [16:0] e_addr;
      logic [5:0]  e_data;
      logic        e_busy;
      logic        e_ovf;
      logic [15:0] e_clip;
   } vec_t;

   localparam int NV = 19;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic we, input logic [8:0] x, input logic [7:0] y,
                               input logic [5:0] c, input logic rdy, input logic e_we,
                               input logic [16:0] e_addr, input logic [5:0] e_data,
                               input logic e_busy, input logic e_ovf, input logic [15:0] e_clip);
      vec_t v;
      v.we = we; v.x = x; v.y = y; v.c = c; v.rdy = rdy;
      v.e_we = e_we; v.e_addr = e_addr; v.e_data = e_data;
      v.e_busy = e_busy; v.e_ovf = e_ovf; v.e_clip = e_clip;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [8:0] x, input logic [7:0] y,
                        input logic [5:0] c, input logic rdy, input logic fin);
      write_en = we; x_in = x; y_in = y; colour_in = c;
      fb_bus.fb_ready = rdy; finished_in = fin;
      tick();
   endtask

   task automatic do_reset(input string tag);
      reset_n = 1'b0;
      drive(1'b0, 9'd0, 8'd0, 6'd0, 1'b0, 1'b0);
      tick();
      check({tag, "_rst_we"},    32'(fb_bus.fb_we), 32'd0);
      check({tag, "_rst_busy"},  32'(busy),         32'd0);
      check({tag, "_rst_done"},  32'(frame_done),   32'd0);
      check({tag, "_rst_ovf"},   32'(overflow),     32'd0);
      check({tag, "_rst_clip"},  32'(clip_count),   32'd0);
      reset_n = 1'b1;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      reset_n = 1'b0;
      write_en = 1'b0; x_in = '0; y_in = '0; colour_in = '0; finished_in = 1'b0;
      fb_bus.fb_ready = 1'b0;

      //             we  x    y    c      rdy  e_we addr    data   busy ovf clip
      tbl[0]  = mk(1, 5,   2,   6'h30, 1,   1,   645,    6'h30, 0,   0,  0);
      tbl[1]  = mk(0, 0,   0,   6'h00, 1,   0,   0,      6'h00, 0,   0,  0);
      tbl[2]  = mk(1, 10,  0,   6'h01, 0,   1,   10,     6'h01, 0,   0,  0);
      tbl[3]  = mk(1, 11,  0,   6'h02, 0,   1,   10,     6'h01, 0,   0,  0);
      tbl[4]  = mk(1, 12,  0,   6'h03, 0,   1,   10,     6'h01, 0,   0,  0);
      tbl[5]  = mk(1, 13,  0,   6'h04, 0,   1,   10,     6'h01, 1,   0,  0);
      tbl[6]  = mk(1, 14,  0,   6'h05, 0,   1,   10,     6'h01, 1,   1,  0);
      tbl[7]  = mk(0, 0,   0,   6'h00, 1,   1,   11,     6'h02, 0,   1,  0);
      tbl[8]  = mk(0, 0,   0,   6'h00, 1,   1,   12,     6'h03, 0,   1,  0);
      tbl[9]  = mk(0, 0,   0,   6'h00, 1,   1,   13,     6'h04, 0,   1,  0);
      tbl[10] = mk(0, 0,   0,   6'h00, 1,   0,   0,      6'h00, 0,   1,  0);
      tbl[11] = mk(0, 0,   0,   6'h00, 1,   0,   0,      6'h00, 0,   1,  0);
      tbl[12] = mk(1, 320, 0,   6'h3F, 1,   0,   0,      6'h00, 0,   1,  1);
      tbl[13] = mk(1, 0,   240, 6'h3F, 1,   0,   0,      6'h00, 0,   1,  2);
      tbl[14] = mk(1, 319, 239, 6'h2A, 1,   1,   76799,  6'h2A, 0,   1,  2);
      tbl[15] = mk(0, 0,   0,   6'h00, 1,   0,   0,      6'h00, 0,   1,  2);
      tbl[16] = mk(1, 1,   1,   6'h11, 1,   1,   321,    6'h11, 0,   1,  2);
      tbl[17] = mk(1, 2,   1,   6'h12, 1,   1,   322,    6'h12, 0,   1,  2);
      tbl[18] = mk(0, 0,   0,   6'h00, 1,   0,   0,      6'h00, 0,   1,  2);

      do_reset("t");
      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].we, tbl[i].x, tbl[i].y, tbl[i].c, tbl[i].rdy, 1'b0);
         check($sformatf("v%0d_we", i),   32'(fb_bus.fb_we), 32'(tbl[i].e_we));
         if (tbl[i].e_we) begin
            check($sformatf("v%0d_addr", i), 32'(fb_bus.fb_addr), 32'(tbl[i].e_addr));
            check($sformatf("v%0d_data", i), 32'(fb_bus.fb_data), 32'(tbl[i].e_data));
         end
         check($sformatf("v%0d_busy", i), 32'(busy),       32'(tbl[i].e_busy));
         check($sformatf("v%0d_ovf", i),  32'(overflow),   32'(tbl[i].e_ovf));
         check($sformatf("v%0d_clip", i), 32'(clip_count), 32'(tbl[i].e_clip));
         check($sformatf("v%0d_done", i), 32'(frame_done), 32'd0);
      end

      // Frame end: three queued pixels, finished_in, then ready alternating.
      do_reset("fe");
      drive(1'b1, 9'd100, 8'd10, 6'h01, 1'b0, 1'b0);
      check("fe_w1_addr", 32'(fb_bus.fb_addr), 32'd3300);
      drive(1'b1, 9'd101, 8'd10, 6'h02, 1'b0, 1'b0);
      drive(1'b1, 9'd102, 8'd10, 6'h03, 1'b0, 1'b0);
      check("fe_w3_busy", 32'(busy), 32'd0);
      drive(1'b0, 9'd0, 8'd0, 6'd0, 1'b1, 1'b1);
      check("fe_f_addr", 32'(fb_bus.fb_addr), 32'd3301);
      check("fe_f_done", 32'(frame_done), 32'd0);
      drive(1'b0, 9'd0, 8'd0, 6'd0, 1'b0, 1'b0);
      check("fe_c1_addr", 32'(fb_bus.fb_addr), 32'd3301);
      check("fe_c1_done", 32'(frame_done), 32'd0);
      drive(1'b0, 9'd0, 8'd0, 6'd0, 1'b1, 1'b0);
      check("fe_c2_addr", 32'(fb_bus.fb_addr), 32'd3302);
      check("fe_c2_data", 32'(fb_bus.fb_data), 32'h03);
      check("fe_c2_done", 32'(frame_done), 32'd0);
      drive(1'b0, 9'd0, 8'd0, 6'd0, 1'b0, 1'b0);
      check("fe_c3_we",   32'(fb_bus.fb_we), 32'd1);
      check("fe_c3_done", 32'(frame_done), 32'd0);
      drive(1'b0, 9'd0, 8'd0, 6'd0, 1'b1, 1'b0);
      check("fe_c4_we",   32'(fb_bus.fb_we), 32'd0);
      check("fe_c4_done", 32'(frame_done), 32'd1);
      drive(1'b0, 9'd0, 8'd0, 6'd0, 1'b0, 1'b0);
      check("fe_c5_done", 32'(frame_done), 32'd0);
      drive(1'b0, 9'd0, 8'd0, 6'd0, 1'b0, 1'b0);
      check("fe_c6_done", 32'(frame_done), 32'd0);

      // Empty frame: finished_in in IDLE gives frame_done two cycles later.
      do_reset("ef");
      drive(1'b0, 9'd0, 8'd0, 6'd0, 1'b1, 1'b1);
      check("ef_c1_done", 32'(frame_done), 32'd0);
      check("ef_c1_we",   32'(fb_bus.fb_we), 32'd0);
      drive(1'b0, 9'd0, 8'd0, 6'd0, 1'b1, 1'b0);
      check("ef_c2_done", 32'(frame_done), 32'd1);
      check("ef_c2_we",   32'(fb_bus.fb_we), 32'd0);
      drive(1'b0, 9'd0, 8'd0, 6'd0, 1'b1, 1'b0);
      check("ef_c3_done", 32'(frame_done), 32'd0);

      // Reset mid-drain discards queued pixels; a later write commits normally.
      do_reset("rm");
      drive(1'b1, 9'd1, 8'd0, 6'h01, 1'b0, 1'b0);
      drive(1'b1, 9'd2, 8'd0, 6'h02, 1'b0, 1'b0);
      drive(1'b1, 9'd3, 8'd0, 6'h03, 1'b0, 1'b1);
      check("rm_q_we",   32'(fb_bus.fb_we), 32'd1);
      check("rm_q_addr", 32'(fb_bus.fb_addr), 32'd1);
      reset_n = 1'b0;
      drive(1'b0, 9'd0, 8'd0, 6'd0, 1'b0, 1'b0);
      reset_n = 1'b1;
      check("rm_r_we",   32'(fb_bus.fb_we), 32'd0);
      check("rm_r_busy", 32'(busy), 32'd0);
      check("rm_r_done", 32'(frame_done), 32'd0);
      drive(1'b0, 9'd0, 8'd0, 6'd0, 1'b1, 1'b0);
      check("rm_i_we",   32'(fb_bus.fb_we), 32'd0);
      check("rm_i_done", 32'(frame_done), 32'd0);
      drive(1'b1, 9'd7, 8'd3, 6'h15, 1'b1, 1'b0);
      check("rm_w_we",   32'(fb_bus.fb_we), 32'd1);
      check("rm_w_addr", 32'(fb_bus.fb_addr), 32'd967);
      check("rm_w_data", 32'(fb_bus.fb_data), 32'h15);
      drive(1'b0, 9'd0, 8'd0, 6'd0, 1'b1, 1'b0);
      check("rm_p_we",   32'(fb_bus.fb_we), 32'd0);
      check("rm_p_done", 32'(frame_done), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
